if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the program counter and drives the instruction-memory request. It also owns the IF/ID pipeline register that feeds the decode stage with instruction, PC and PC+4. It supports variable-latency instruction memory, decode stalls, and branch/jump redirects from EX with bubble insertion.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, instruction (addi x0,x0,0) loaded into IF/ID for bubbles.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
stall_i  in  1  hold IF/ID register and PC (load-use hazard from decode).
flush_i  in  1  replace IF/ID contents with bubble next edge.
br_taken_i  in  1  redirect from EX (taken branch/jal/jalr).
br_target_i  in  32  redirect target, valid when br_taken_i=1.
imem_req_o  out  1  instruction-memory request.
imem_addr_o  out  32  fetch address; stable while imem_req_o=1 and imem_ready_i=0.
imem_rdata_i  in  32  instruction word, valid in the cycle imem_ready_i=1.
imem_ready_i  in  1  request accepted and data returned this cycle.
inst_d_o  out  32  IF/ID instruction.
pc_d_o  out  32  IF/ID PC.
pc4_d_o  out  32  IF/ID PC+4.
valid_d_o  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (async, rst_i=1): pc_r=RESET_PC; state=FETCH; inst_d_o=NOP_INST; pc_d_o=0; pc4_d_o=0; valid_d_o=0; skid buffer cleared. imem_req_o is decoded from state, so it reads 1 as soon as reset releases. Reset mid-transaction abandons any outstanding request and returns the pending data to nothing.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0. br_target_i is used as given, with no alignment check.
- A "delivery" is one of: FETCH with ready=1, or the exit from HOLD.
- IF/ID update priority per edge: flush_i|br_taken_i > stall_i > delivery > bubble.
  - flush/redirect: load NOP_INST, valid=0. pc_d and pc4_d may take any value.
  - stall: hold all IF/ID fields.
  - delivery: load inst, pc, pc+4, valid=1.
  - otherwise: load a bubble (NOP, valid=0).
- States:
  - FETCH: imem_req_o=1, imem_addr_o=pc_r.
    - br_taken_i with ready=1: discard data; pc_r<=br_target_i; stay in FETCH.
    - br_taken_i with ready=0: drain_addr<=pc_r; pc_r<=br_target_i; go to DRAIN.
    - ready=1, stall_i=0: deliver; pc_r<=pc_r+4.
    - ready=1, stall_i=1: skid<=rdata; skid_pc<=pc_r; pc_r<=pc_r+4; go to HOLD.
    - ready=0: stay; address held stable.
  - HOLD: imem_req_o=0.
    - br_taken_i: drop skid; pc_r<=br_target_i; go to FETCH.
    - stall_i=0: deliver skid/skid_pc; go to FETCH.
    - otherwise: stay.
  - DRAIN: imem_req_o=1, imem_addr_o=drain_addr, so the outstanding request is never changed.
    - ready=1: discard data; go to FETCH.
    - A new br_taken_i in DRAIN overwrites pc_r only.
- Latency: with zero-wait memory (ready same cycle) and no hazards, one instruction per clock. The instruction fetched at PC appears on IF/ID one edge after it is requested.
- flush_i alone does not change pc_r or state. Redirects always come through br_taken_i.
- Simultaneous stall_i and br_taken_i: the redirect wins. IF/ID is bubbled and the PC is redirected.
- At most one outstanding request.

Test Plan:
- Reset then zero-wait memory returning 0x00A00093, 0x00100113, 0x002081B3:
  - PC sequence 0, 4, 8.
  - IF/ID gets (0x00A00093, 0, 4, valid=1) one edge after the first request, then consecutive entries.
  - During reset: inst_d=0x13, valid=0.
- Memory ready after 3 cycles:
  - imem_addr_o held at 0x4 for all 3 waiting cycles.
  - Bubbles (0x13, valid=0) appear in IF/ID meanwhile.
  - Delivery occurs on the ready cycle only.
- stall_i=1 for 2 cycles while ready=1 at PC 0x8:
  - IF/ID held at PC 0x4; state goes to HOLD with imem_req_o=0.
  - After release, IF/ID gets PC 0x8 and fetch resumes at 0xC.
  - No instruction is lost or duplicated.
- br_taken_i=1, br_target_i=0x100 while a request to 0x10 is waiting:
  - addr stays 0x10 until ready; that data is dropped.
  - Next request goes to 0x100; IF/ID shows valid=0 until 0x100 delivers.
- stall_i and br_taken_i (target 0x40) asserted in the same cycle:
  - IF/ID becomes bubble; next fetch address is 0x40.
- RESET_PC=0xFFFF_FFFC:
  - First fetch at 0xFFFF_FFFC, then 0x0; pc4_d_o=0x0 for the first instruction.
- rst_i pulsed while in DRAIN:
  - All outputs return to reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage_if.sv
// Fetch-stage bus: decode-side hazard/redirect controls, instruction-memory
// handshake, and the IF/ID pipeline-register outputs.
interface if_stage_if;
   logic        stall_i;
   logic        flush_i;
   logic        br_taken_i;
   logic [31:0] br_target_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic        imem_ready_i;
   logic [31:0] inst_d_o;
   logic [31:0] pc_d_o;
   logic [31:0] pc4_d_o;
   logic        valid_d_o;

   modport master (
      input  stall_i, flush_i, br_taken_i, br_target_i, imem_rdata_i, imem_ready_i,
      output imem_req_o, imem_addr_o, inst_d_o, pc_d_o, pc4_d_o, valid_d_o
   );

   modport slave (
      output stall_i, flush_i, br_taken_i, br_target_i, imem_rdata_i, imem_ready_i,
      input  imem_req_o, imem_addr_o, inst_d_o, pc_d_o, pc4_d_o, valid_d_o
   );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem request,
// one-entry skid for stalled returns, and the IF/ID pipeline register.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input logic         clk_i,
   input logic         rst_i,
   if_stage_if.master  bus
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   drain_addr_q, drain_addr_d;
   logic [XLEN-1:0]   skid_inst_q, skid_inst_d;
   logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
   logic [XLEN-1:0]   inst_q, inst_d;
   logic [XLEN-1:0]   pcid_q, pcid_d;
   logic [XLEN-1:0]   pc4_q, pc4_d;
   logic              valid_q, valid_d;

   logic              deliver;
   logic [XLEN-1:0]   dlv_inst;
   logic [XLEN-1:0]   dlv_pc;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         drain_addr_q <= '0;
         skid_inst_q  <= '0;
         skid_pc_q    <= '0;
         inst_q       <= NOP_INST;
         pcid_q       <= '0;
         pc4_q        <= '0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         skid_inst_q  <= skid_inst_d;
         skid_pc_q    <= skid_pc_d;
         inst_q       <= inst_d;
         pcid_q       <= pcid_d;
         pc4_q        <= pc4_d;
         valid_q      <= valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      skid_inst_d  = skid_inst_q;
      skid_pc_d    = skid_pc_q;
      inst_d       = inst_q;
      pcid_d       = pcid_q;
      pc4_d        = pc4_q;
      valid_d      = valid_q;
      deliver      = 1'b0;
      dlv_inst     = bus.imem_rdata_i;
      dlv_pc       = pc_q;

      unique case (state_q)
         S_FETCH: begin
            if (bus.br_taken_i) begin
               pc_d = bus.br_target_i;
               // An unanswered request must be seen through at its original address.
               if (!bus.imem_ready_i) begin
                  drain_addr_d = pc_q;
                  state_d      = S_DRAIN;
               end
            end else if (bus.imem_ready_i) begin
               pc_d = pc_q + XLEN'(4);
               if (bus.stall_i) begin
                  skid_inst_d = bus.imem_rdata_i;
                  skid_pc_d   = pc_q;
                  state_d     = S_HOLD;
               end else begin
                  deliver = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (bus.br_taken_i) begin
               pc_d    = bus.br_target_i;
               state_d = S_FETCH;
            end else if (!bus.stall_i) begin
               deliver  = 1'b1;
               dlv_inst = skid_inst_q;
               dlv_pc   = skid_pc_q;
               state_d  = S_FETCH;
            end
         end
         S_DRAIN: begin
            if (bus.br_taken_i) pc_d = bus.br_target_i;
            if (bus.imem_ready_i) state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // IF/ID: redirect/flush > stall > delivery > bubble; bubbles keep stale PC fields.
      if (bus.flush_i || bus.br_taken_i) begin
         inst_d  = NOP_INST;
         valid_d = 1'b0;
      end else if (bus.stall_i) begin
         inst_d  = inst_q;
      end else if (deliver) begin
         inst_d  = dlv_inst;
         pcid_d  = dlv_pc;
         pc4_d   = dlv_pc + XLEN'(4);
         valid_d = 1'b1;
      end else begin
         inst_d  = NOP_INST;
         valid_d = 1'b0;
      end
   end

   assign bus.imem_req_o  = (state_q != S_HOLD);
   assign bus.imem_addr_o = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
   assign bus.inst_d_o    = inst_q;
   assign bus.pc_d_o      = pcid_q;
   assign bus.pc4_d_o     = pc4_q;
   assign bus.valid_d_o   = valid_q;
endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: two instances (RESET_PC 0 and 0xFFFF_FFFC)
// share stimulus; a fetch-queue reference model predicts every cycle's outputs.
module tb_if_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        valid;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   if_stage_if ifa ();
   if_stage_if ifb ();

   function automatic logic [31:0] memfn(input logic [31:0] a);
      case (a)
         32'h0: memfn = 32'h00A0_0093;
         32'h4: memfn = 32'h0010_0113;
         32'h8: memfn = 32'h0020_81B3;
         default: memfn = (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
      endcase
   endfunction

   assign ifa.imem_rdata_i = memfn(ifa.imem_addr_o);
   assign ifb.imem_rdata_i = memfn(ifb.imem_addr_o);

   if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) u_dut0 (.clk_i(clk), .rst_i(rst), .bus(ifa));
   if_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(ifb));

   // Reference model: pc, at most one abandoned request still owed, at most one parked word.
   logic [31:0] rpc [2];
   logic [31:0] m_pc [2];
   logic        m_owed [2];
   logic [31:0] m_owed_addr [2];
   logic        m_park [2];
   logic [31:0] m_park_inst [2];
   logic [31:0] m_park_pc [2];
   exp_t        m_ifid [2];

   exp_t q0[$];
   exp_t q1[$];
   int n_vec = 0;
   int n_cmp = 0;
   int n_err = 0;

   function automatic exp_t model_out(input int k);
      exp_t e;
      e       = m_ifid[k];
      e.req   = !m_park[k];
      e.addr  = m_owed[k] ? m_owed_addr[k] : m_pc[k];
      return e;
   endfunction

   task automatic model_reset(input int k);
      m_pc[k]        = rpc[k];
      m_owed[k]      = 1'b0;
      m_owed_addr[k] = '0;
      m_park[k]      = 1'b0;
      m_park_inst[k] = '0;
      m_park_pc[k]   = '0;
      m_ifid[k]      = '{req: 1'b1, addr: '0, inst: NOP, pc: '0, pc4: '0, valid: 1'b0};
   endtask

   task automatic model_step(input int k, input logic st, input logic fl, input logic br,
                             input logic [31:0] tgt, input logic rdy);
      logic        got;
      logic [31:0] g_inst, g_pc;
      got = 1'b0; g_inst = '0; g_pc = '0;
      if (m_park[k]) begin
         if (br) begin
            m_park[k] = 1'b0; m_pc[k] = tgt;
         end else if (!st) begin
            got = 1'b1; g_inst = m_park_inst[k]; g_pc = m_park_pc[k]; m_park[k] = 1'b0;
         end
      end else if (m_owed[k]) begin
         if (br) m_pc[k] = tgt;
         if (rdy) m_owed[k] = 1'b0;
      end else if (br) begin
         if (!rdy) begin m_owed[k] = 1'b1; m_owed_addr[k] = m_pc[k]; end
         m_pc[k] = tgt;
      end else if (rdy) begin
         if (st) begin
            m_park[k] = 1'b1; m_park_inst[k] = memfn(m_pc[k]); m_park_pc[k] = m_pc[k];
         end else begin
            got = 1'b1; g_inst = memfn(m_pc[k]); g_pc = m_pc[k];
         end
         m_pc[k] = m_pc[k] + 32'd4;
      end
      if (fl || br) begin
         m_ifid[k].inst = NOP; m_ifid[k].valid = 1'b0;
      end else if (st) begin
         m_ifid[k] = m_ifid[k];
      end else if (got) begin
         m_ifid[k].inst = g_inst; m_ifid[k].pc = g_pc; m_ifid[k].pc4 = g_pc + 32'd4;
         m_ifid[k].valid = 1'b1;
      end else begin
         m_ifid[k].inst = NOP; m_ifid[k].valid = 1'b0;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
      end
   endtask

   task automatic check_dut(input int k, input exp_t e, input logic req, input logic [31:0] addr,
                            input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] pc4,
                            input logic valid);
      chk($sformatf("dut%0d imem_req", k), 32'(req), 32'(e.req));
      if (e.req) chk($sformatf("dut%0d imem_addr", k), addr, e.addr);
      chk($sformatf("dut%0d inst_d", k), inst, e.inst);
      chk($sformatf("dut%0d valid_d", k), 32'(valid), 32'(e.valid));
      if (e.valid) begin
         chk($sformatf("dut%0d pc_d", k), pc, e.pc);
         chk($sformatf("dut%0d pc4_d", k), pc4, e.pc4);
      end
   endtask

   // Monitor: compares whatever the DUTs present against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check_dut(0, e, ifa.imem_req_o, ifa.imem_addr_o, ifa.inst_d_o, ifa.pc_d_o,
                      ifa.pc4_d_o, ifa.valid_d_o);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check_dut(1, e, ifb.imem_req_o, ifb.imem_addr_o, ifb.inst_d_o, ifb.pc_d_o,
                      ifb.pc4_d_o, ifb.valid_d_o);
         end
      end
   end

   task automatic drive(input logic st, input logic fl, input logic br,
                        input logic [31:0] tgt, input logic rdy);
      ifa.stall_i = st; ifa.flush_i = fl; ifa.br_taken_i = br; ifa.br_target_i = tgt;
      ifa.imem_ready_i = rdy;
      ifb.stall_i = st; ifb.flush_i = fl; ifb.br_taken_i = br; ifb.br_target_i = tgt;
      ifb.imem_ready_i = rdy;
   endtask

   task automatic step(input logic r, input logic st, input logic fl, input logic br,
                       input logic [31:0] tgt, input logic rdy);
      @(negedge clk);
      #1;
      rst = r;
      drive(st, fl, br, tgt, rdy);
      for (int k = 0; k < 2; k++) begin
         if (r) model_reset(k);
         else   model_step(k, st, fl, br, tgt, rdy);
      end
      q0.push_back(model_out(0));
      q1.push_back(model_out(1));
      n_vec++;
   endtask

   // Reset raised between edges must show on the outputs before any clock edge.
   task automatic async_reset_check();
      exp_t e;
      @(negedge clk);
      #1;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 2; k++) model_reset(k);
      #1;
      e = model_out(0);
      check_dut(0, e, ifa.imem_req_o, ifa.imem_addr_o, ifa.inst_d_o, ifa.pc_d_o,
                ifa.pc4_d_o, ifa.valid_d_o);
      e = model_out(1);
      check_dut(1, e, ifb.imem_req_o, ifb.imem_addr_o, ifb.inst_d_o, ifb.pc_d_o,
                ifb.pc4_d_o, ifb.valid_d_o);
      q0.push_back(model_out(0));
      q1.push_back(model_out(1));
      n_vec++;
   endtask

   initial begin
      rpc[0] = 32'h0000_0000;
      rpc[1] = 32'hFFFF_FFFC;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 2; k++) model_reset(k);

      // Zero-wait stream.
      step(1, 0, 0, 0, 32'h0, 0);
      step(1, 0, 0, 0, 32'h0, 0);
      repeat (3) step(0, 0, 0, 0, 32'h0, 1);
      // Three wait cycles at the second address.
      step(1, 0, 0, 0, 32'h0, 0);
      step(0, 0, 0, 0, 32'h0, 1);
      repeat (3) step(0, 0, 0, 0, 32'h0, 0);
      step(0, 0, 0, 0, 32'h0, 1);
      // Stall for two cycles while memory answers.
      step(0, 1, 0, 0, 32'h0, 1);
      step(0, 1, 0, 0, 32'h0, 1);
      step(0, 0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 0, 32'h0, 1);
      // Redirect while a request is waiting.
      step(0, 0, 0, 1, 32'h100, 0);
      step(0, 0, 0, 0, 32'h0, 0);
      step(0, 0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 0, 32'h0, 1);
      // Stall and redirect together.
      step(0, 1, 0, 1, 32'h40, 1);
      step(0, 0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 0, 32'h0, 1);
      // Reset while draining.
      step(0, 0, 0, 1, 32'h200, 0);
      step(0, 0, 0, 0, 32'h0, 0);
      async_reset_check();
      step(0, 0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 0, 32'h0, 1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic r, st, fl, br, rdy;
         logic [31:0] tgt;
         r   = ($urandom_range(0, 199) == 0);
         st  = ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 9) == 0);
         br  = ($urandom_range(0, 9) == 0);
         rdy = ($urandom_range(0, 9) < 6);
         tgt = $urandom();
         if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
         step(r, st, fl, br, tgt, rdy);
      end

      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
